// File: rtl/lce_pkg.sv
// Shared types and helpers for the line-clear engine.
// Holds the FSM state encoding, the row base-index helper and the
// saturating score accumulator used when a job completes.
package lce_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SCAN,
      FLASH,
      COLLAPSE,
      DONE
   } state_t;

   // Bit position of column 0 of a row in the flattened board vector.
   function automatic int row_base(input int row, input int width);
      return row * width;
   endfunction

   // score + n*n, where the product is truncated to score_w+1 bits and the
   // sum saturates at 2^score_w-1.
   function automatic longint unsigned score_add(input longint unsigned cur_score,
                                                 input longint unsigned n,
                                                 input int score_w);
      longint unsigned prod;
      longint unsigned sum;
      longint unsigned max_score;
      prod      = (n * n) & ((64'd1 << (score_w + 1)) - 64'd1);
      sum       = cur_score + prod;
      max_score = (64'd1 << score_w) - 64'd1;
      return (sum > max_score) ? max_score : sum;
   endfunction

endpackage

// File: rtl/line_clear_engine_row_full_detect.sv
// Combinational full-row detector: a row is full when every cell is set.
module row_full_detect #(
   parameter int WIDTH = 10
) (
   input  logic [WIDTH-1:0] row,
   output logic             full
);

   // AND-reduce the row.
   assign full = &row;

endmodule

// File: rtl/line_clear_engine.sv
// Playfield line-clear engine.
// Accepts a locked board snapshot, scans bottom-up for full rows, flashes
// them for FLASH_CYCLES cycles, collapses the board downward, then reports
// the new board, the number of rows cleared and a saturating score.
// Optional build macro LCE_BLINK_EN: flash_out blinks with half-period
// BLINK_PERIOD during the flash phase instead of holding solid.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid, once raised, holds its payload stable until that edge,
// and ready may be raised or lowered independently of valid.
module line_clear_engine
   import lce_pkg::*;
#(
   parameter int BOARD_W      = 10,
   parameter int BOARD_H      = 20,
   parameter int FLASH_CYCLES = 4,
   parameter int SCORE_W      = 7,
   parameter int BLINK_PERIOD = 2
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [BOARD_W*BOARD_H-1:0]         board_in,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [BOARD_W*BOARD_H-1:0]         board_out,
   output logic [BOARD_W*BOARD_H-1:0]         flash_out,
   output logic [$clog2(BOARD_H+1)-1:0]       lines_cleared,
   output logic [SCORE_W-1:0]                 score,
   output logic                               busy
);

   localparam int N  = BOARD_W * BOARD_H;
   localparam int RW = $clog2(BOARD_H);
   localparam int NW = $clog2(BOARD_H + 1);
   localparam int CW = $clog2(2 * BOARD_H + 1);
   localparam int FW = $clog2(FLASH_CYCLES + 1);

   if (BOARD_W < 2 || BOARD_H < 2 || FLASH_CYCLES < 1 || BLINK_PERIOD < 1 || SCORE_W < 1) begin : g_bad_param
      $error("line_clear_engine: parameter out of range");
   end

   state_t          state;
   logic [N-1:0]    work;
   logic [BOARD_H-1:0] mask;
   logic [RW-1:0]   rd;
   logic [RW-1:0]   wr;
   logic [NW-1:0]   n_rows;
   logic [FW-1:0]   flash_cnt;
   logic [CW-1:0]   coll_cnt;
   logic            rd_done;

   logic [BOARD_W-1:0] rd_row;
   logic               row_full;
   logic [BOARD_H-1:0] scan_mask;
   logic [N-1:0]       scan_exp;
   logic [NW-1:0]      scan_n;
   logic [CW-1:0]      coll_last;

`ifdef LCE_BLINK_EN
   localparam int BW = $clog2(BLINK_PERIOD + 1);
   logic [BW-1:0] blink_cnt;
   logic [N-1:0]  mask_exp;
`endif

   // Select the row currently addressed by the read pointer.
   always_comb begin
      rd_row = work[row_base(int'(rd), BOARD_W) +: BOARD_W];
   end

   row_full_detect #(.WIDTH(BOARD_W)) u_row_full (
      .row  (rd_row),
      .full (row_full)
   );

   // Mask and count including the row being scanned this cycle, plus its
   // cell-level expansion used to load flash_out on entry to FLASH.
   always_comb begin
      scan_mask = mask | (BOARD_H'(row_full) << rd);
      scan_n    = n_rows + NW'(row_full);
      coll_last = CW'(BOARD_H - 1) + CW'(n_rows);
      scan_exp  = '0;
      for (int r = 0; r < BOARD_H; r++) begin
         scan_exp[r*BOARD_W +: BOARD_W] = {BOARD_W{scan_mask[r]}};
      end
   end

`ifdef LCE_BLINK_EN
   // Cell-level expansion of the final mask, re-shown on each blink-on phase.
   always_comb begin
      mask_exp = '0;
      for (int r = 0; r < BOARD_H; r++) begin
         mask_exp[r*BOARD_W +: BOARD_W] = {BOARD_W{mask[r]}};
      end
   end
`endif

   // Main FSM: state, work board, pointers and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         in_ready      <= 1'b1;
         out_valid     <= 1'b0;
         busy          <= 1'b0;
         board_out     <= '0;
         flash_out     <= '0;
         lines_cleared <= '0;
         score         <= '0;
         work          <= '0;
         mask          <= '0;
         rd            <= '0;
         wr            <= '0;
         n_rows        <= '0;
         flash_cnt     <= '0;
         coll_cnt      <= '0;
         rd_done       <= 1'b0;
`ifdef LCE_BLINK_EN
         blink_cnt     <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  work     <= board_in;
                  mask     <= '0;
                  n_rows   <= '0;
                  rd       <= RW'(BOARD_H - 1);
                  state    <= SCAN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end

            SCAN: begin
               mask   <= scan_mask;
               n_rows <= scan_n;
               if (rd == '0) begin
                  rd <= RW'(BOARD_H - 1);
                  wr <= RW'(BOARD_H - 1);
                  if (scan_n == '0) begin
                     state <= DONE;
                  end else begin
                     state     <= FLASH;
                     flash_out <= scan_exp;
                     flash_cnt <= '0;
`ifdef LCE_BLINK_EN
                     blink_cnt <= '0;
`endif
                  end
               end else begin
                  rd <= rd - RW'(1);
               end
            end

            FLASH: begin
               if (flash_cnt == FW'(FLASH_CYCLES - 1)) begin
                  state     <= COLLAPSE;
                  flash_out <= '0;
                  rd        <= RW'(BOARD_H - 1);
                  wr        <= RW'(BOARD_H - 1);
                  coll_cnt  <= '0;
                  rd_done   <= 1'b0;
               end else begin
                  flash_cnt <= flash_cnt + FW'(1);
`ifdef LCE_BLINK_EN
                  if (blink_cnt == BW'(BLINK_PERIOD - 1)) begin
                     blink_cnt <= '0;
                     flash_out <= (flash_out == '0) ? mask_exp : '0;
                  end else begin
                     blink_cnt <= blink_cnt + BW'(1);
                  end
`endif
               end
            end

            COLLAPSE: begin
               // Rows below wr are never written before they are read, so
               // the live detector on row rd sees the original contents.
               coll_cnt <= coll_cnt + CW'(1);
               if (coll_cnt == coll_last) begin
                  state <= DONE;
               end
               if (!rd_done) begin
                  if (!row_full) begin
                     work[row_base(int'(wr), BOARD_W) +: BOARD_W] <= rd_row;
                     wr <= wr - RW'(1);
                  end
                  if (rd == '0) begin
                     rd_done <= 1'b1;
                  end else begin
                     rd <= rd - RW'(1);
                  end
               end else begin
                  work[row_base(int'(wr), BOARD_W) +: BOARD_W] <= '0;
                  wr <= wr - RW'(1);
               end
            end

            DONE: begin
               if (!out_valid) begin
                  board_out     <= work;
                  lines_cleared <= n_rows;
                  score         <= SCORE_W'(score_add(64'(score), 64'(n_rows), SCORE_W));
                  out_valid     <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_line_clear_engine.sv
// Randomised scoreboard bench for line_clear_engine (default build).
module tb_line_clear_engine;

  localparam int W  = 10;
  localparam int H  = 20;
  localparam int F  = 4;
  localparam int SW = 7;
  localparam int N  = W * H;
  localparam int NW = $clog2(H + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  board_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  board_out;
  logic [N-1:0]  flash_out;
  logic [NW-1:0] lines_cleared;
  logic [SW-1:0] score;
  logic          busy;

  line_clear_engine #(
    .BOARD_W(W), .BOARD_H(H), .FLASH_CYCLES(F), .SCORE_W(SW), .BLINK_PERIOD(2)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .board_in(board_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .board_out(board_out), .flash_out(flash_out),
    .lines_cleared(lines_cleared), .score(score), .busy(busy)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] exp_flash_q[$];
  int           exp_lines_q[$];
  int           exp_score_q[$];
  int           exp_lat_q[$];
  int           exp_fcnt_q[$];
  int           acc_q[$];

  int model_score = 0;
  int ready_mode  = 0;  // 0: random consumer, 1: bench drives out_ready

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event not expected or not seen", name);
  endtask

  // ---------------- reference model ----------------
  // Full rows vanish; the remaining rows keep their order and settle at the bottom.
  task automatic model(input logic [N-1:0] b, output logic [N-1:0] o,
                       output logic [N-1:0] fl, output int n);
    logic [W-1:0] rows_left[$];
    logic [W-1:0] row;
    o = '0; fl = '0; n = 0;
    for (int r = 0; r < H; r++) begin
      row = b[r*W +: W];
      if (row == {W{1'b1}}) begin
        n++;
        fl[r*W +: W] = {W{1'b1}};
      end else begin
        rows_left.push_back(row);
      end
    end
    for (int i = 0; i < rows_left.size(); i++) begin
      o[(n + i)*W +: W] = rows_left[i];
    end
  endtask

  function automatic int score_model(input int s, input int n);
    int prod;
    int lim;
    prod = (n * n) % (1 << (SW + 1));
    lim  = (1 << SW) - 1;
    return (s + prod > lim) ? lim : s + prod;
  endfunction

  function automatic logic [N-1:0] rand_board(input int full_pct);
    logic [N-1:0] b;
    logic [W-1:0] row;
    b = '0;
    for (int r = 0; r < H; r++) begin
      if (int'($urandom_range(0, 99)) < full_pct) row = {W{1'b1}};
      else row = W'($urandom) & W'($urandom);
      b[r*W +: W] = row;
    end
    return b;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [N-1:0] b);
    int guard;
    logic [N-1:0] eo;
    logic [N-1:0] ef;
    int n;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    board_in = b;
    while (!in_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check_fail("send_timeout");
      in_valid = 1'b0;
      return;
    end
    model(b, eo, ef, n);
    model_score = score_model(model_score, n);
    exp_q.push_back(eo);
    exp_flash_q.push_back(ef);
    exp_lines_q.push_back(n);
    exp_score_q.push_back(model_score);
    exp_lat_q.push_back((n == 0) ? H + 1 : H + F + H + n + 1);
    exp_fcnt_q.push_back((n == 0) ? 0 : F);
    acc_q.push_back(cyc + 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || !in_ready) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) check_fail("drain_timeout");
  endtask

  // ---------------- consumer ----------------
  always @(negedge clk) begin
    if (ready_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor ----------------
  logic         prev_valid = 1'b0;
  int           flash_seen = 0;
  logic [N-1:0] hold_board;
  int           hold_lines;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      flash_seen = 0;
    end else begin
      if (flash_out != '0) begin
        if (exp_flash_q.size() == 0) check_fail("flash_unexpected");
        else check("flash_pattern", flash_out, exp_flash_q[0]);
        flash_seen++;
      end
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check_fail("unexpected_result");
        end else begin
          hold_board = exp_q.pop_front();
          hold_lines = exp_lines_q.pop_front();
          void'(exp_flash_q.pop_front());
          check("board_out", board_out, hold_board);
          check("lines_cleared", N'(lines_cleared), N'(hold_lines));
          check("score", N'(score), N'(exp_score_q.pop_front()));
          check("latency", N'(cyc - acc_q.pop_front()), N'(exp_lat_q.pop_front()));
          check("flash_cycles", N'(flash_seen), N'(exp_fcnt_q.pop_front()));
        end
        flash_seen = 0;
      end else if (out_valid) begin
        check("hold_board", board_out, hold_board);
        check("hold_lines", N'(lines_cleared), N'(hold_lines));
      end
      prev_valid = out_valid;
    end
  end

  // ---------------- stimulus ----------------
  logic [N-1:0] b;
  logic [N-1:0] eo;
  logic [N-1:0] ef;
  int           en;
  int           guard;
  int           stray;

  initial begin
    do_reset();
    #1;
    check("rst_in_ready", N'(in_ready), N'(1));
    check("rst_out_valid", N'(out_valid), N'(0));
    check("rst_busy", N'(busy), N'(0));
    check("rst_board_out", board_out, '0);
    check("rst_flash_out", flash_out, '0);
    check("rst_lines", N'(lines_cleared), N'(0));
    check("rst_score", N'(score), N'(0));

    // Empty board, single bottom row, split full rows.
    send('0);
    b = '0;
    b[199:190] = '1;
    b[180] = 1'b1;
    send(b);
    b = '0;
    b[16*W +: W] = '1;
    b[17*W +: W] = 10'h001;
    b[18*W +: W] = '1;
    b[19*W +: W] = 10'h155;
    send(b);

    for (int i = 0; i < 10; i++) send(rand_board(25));

    // Every row full: board empties, n = H.
    b = '1;
    send(b);
    drain();

    // Consumer stalls: result held, new offers ignored.
    ready_mode = 1;
    out_ready = 1'b0;
    b = rand_board(30);
    model(b, eo, ef, en);
    send(b);
    guard = 0;
    while (!out_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid) check_fail("stall_wait_valid");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      board_in = rand_board(50);
      @(negedge clk);
      check("stall_board", board_out, eo);
      check("stall_lines", N'(lines_cleared), N'(en));
      check("stall_in_ready", N'(in_ready), N'(0));
      check("stall_out_valid", N'(out_valid), N'(1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_out_valid", N'(out_valid), N'(0));
    check("release_in_ready", N'(in_ready), N'(1));
    check("release_busy", N'(busy), N'(0));
    ready_mode = 0;
    drain();

    // Reset on the second flash cycle aborts the job.
    b = '0;
    b[19*W +: W] = '1;
    send(b);
    guard = 0;
    while (flash_out == '0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (flash_out == '0) check_fail("abort_wait_flash");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_flash_out", flash_out, '0);
    check("abort_in_ready", N'(in_ready), N'(1));
    check("abort_busy", N'(busy), N'(0));
    check("abort_score", N'(score), N'(0));
    exp_q.delete(); exp_flash_q.delete(); exp_lines_q.delete();
    exp_score_q.delete(); exp_lat_q.delete(); exp_fcnt_q.delete(); acc_q.delete();
    model_score = 0;
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    check("abort_no_output", N'(stray), N'(0));

    for (int i = 0; i < 6; i++) send(rand_board(20));
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/line_clear_engine.md
Name: line_clear_engine

Overview:
- Parametrised playfield line-clear unit for the Tetris datapath.
- Accepts a locked board snapshot and scans for full rows. Drives a flash mask over those rows for a programmable time, then collapses the board downward.
- Reports lines cleared and keeps a saturating score.
- Sits between the piece-lock logic and the display/board register. Generalises the fixed 10x20 board to any W x H.

Parameters:
- BOARD_W, 10, columns per row (>=2)
- BOARD_H, 20, rows (>=2)
- FLASH_CYCLES, 4, cycles the flash phase lasts (>=1)
- SCORE_W, 7, score register width
- BLINK_PERIOD, 2, half-period of flash blink in cycles (used only with LCE_BLINK_EN)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  board snapshot offered
- in_ready  out  1  engine idle, can accept
- board_in  in  BOARD_W*BOARD_H  snapshot; bit r*BOARD_W+c, row 0 top, row BOARD_H-1 bottom
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- board_out  out  BOARD_W*BOARD_H  collapsed board, same bit mapping
- flash_out  out  BOARD_W*BOARD_H  1 = cell flashing
- lines_cleared  out  $clog2(BOARD_H+1)  full rows found in last job
- score  out  SCORE_W  accumulated score
- busy  out  1  state != IDLE

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. All outputs are registered.
  - Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0.
  - Reset clears board_out, flash_out, lines_cleared and score to 0.
  - rst in any state aborts the job at the next edge; no partial result is output.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch board_in into the work register, clear the full-row mask, set rd=BOARD_H-1, go to SCAN.
- SCAN:
  - One row per cycle, BOARD_H cycles, rows H-1 down to 0.
  - A row is marked full iff all BOARD_W bits are 1.
  - n = popcount of the mask.
  - Next state: n==0 -> DONE; otherwise FLASH.
- FLASH:
  - FLASH_CYCLES cycles. flash_out = all cells of marked rows.
  - Then go to COLLAPSE with rd=wr=BOARD_H-1.
  - flash_out returns to 0 on leaving FLASH.
- COLLAPSE: one action per cycle.
  - rd row full: rd--.
  - rd row not full: copy row rd to row wr, then rd--, wr--.
  - After row 0 has been read: zero row wr, then wr--, for the remaining n fill cycles.
  - Takes exactly BOARD_H+n cycles, then go to DONE.
- DONE:
  - Register board_out and lines_cleared=n.
  - Score update: score += n*n, saturating at 2^SCORE_W-1. The product is computed at SCORE_W+1 bits before the saturate.
  - Assert out_valid.
- Output handshake:
  - out_valid stays high with board_out and lines_cleared stable until out_ready.
  - On out_valid&&out_ready, clear out_valid and return to IDLE. in_ready rises the following cycle, so there is one bubble between jobs.
- Latency, accept edge to first out_valid cycle:
  - n==0: BOARD_H+1.
  - n>0: BOARD_H+FLASH_CYCLES+BOARD_H+n+1.
- Boundary cases:
  - All rows full: board_out is all zero and n=BOARD_H.
  - in_valid while busy: ignored, in_ready=0.
  - out_ready high without out_valid: no effect.

Optional Feature:
- LCE_BLINK_EN defined:
  - During FLASH, flash_out toggles between the mask and 0 every BLINK_PERIOD cycles, starting with the mask visible.
  - FLASH duration is unchanged.
- LCE_BLINK_EN undefined: flash_out holds the mask solid for all of FLASH.

Decomposition:
- Shared package lce_pkg:
  - State enum {IDLE, SCAN, FLASH, COLLAPSE, DONE}.
  - Row index helper function.
  - Score saturating-add function.
- One natural sub-module: row_full_detect, a combinational AND-reduce of one BOARD_W-bit row, instanced once on the rd-selected row.

Test Plan (BOARD_W=10, BOARD_H=20, FLASH_CYCLES=4, SCORE_W=7 unless stated):
1. Empty board -> out_valid 21 cycles after accept; lines_cleared=0; score=0; flash_out never nonzero.
2. Row 19 full, bit 180 set -> flash_out bits 190..199 high for exactly 4 cycles; board_out has only bit 190 set; lines_cleared=1; score=1; latency 46.
3. Rows 16 and 18 full, row 17=10'h001, row 19=10'h155 -> board_out row 19=10'h155, row 18=10'h001, rows 0-17 zero; lines_cleared=2; score=4.
4. SCORE_W=4, two jobs each with 3 full bottom rows -> score 9, then saturates at 15 (not 18 wrapped to 2).
5. rst asserted on 2nd FLASH cycle -> next cycle flash_out=0, in_ready=1, busy=0, score=0, out_valid never asserts.
6. Hold out_ready=0 for 5 cycles after out_valid -> board_out/lines_cleared stable, in_ready=0, in_valid ignored; out_ready=1 -> out_valid drops, in_ready=1 next cycle.
